// File: rtl/bslu_seq.sv
// bslu_seq: expands one COPY/AND/XOR/ADD command into a bit-serial BSLU micro-op and row-strobe stream.
// Define BSLU_SEQ_CARRY_OUT_EN to have ADD write its carry-out to row cmd_d+nbits.
module bslu_seq #(
    parameter int unsigned ROW_AW = 10,
    parameter int unsigned NB_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [NB_W-1:0]   cmd_nbits,
    input  logic [ROW_AW-1:0] cmd_a,
    input  logic [ROW_AW-1:0] cmd_b,
    input  logic [ROW_AW-1:0] cmd_d,
    input  logic              uop_stall,
    output logic [5:0]        uop_op,
    output logic [2:0]        uop_rs1,
    output logic [2:0]        uop_rs2,
    output logic [2:0]        uop_rd,
    output logic              row_rd,
    output logic              row_wr,
    output logic [ROW_AW-1:0] row_addr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BC_W = NB_W + 1;

    localparam logic [1:0] OP_COPY = 2'd0;
    localparam logic [1:0] OP_AND  = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_ADD  = 2'd3;

    localparam logic [2:0] R_SA = 3'b001;
    localparam logic [2:0] R_CR = 3'b010;
    localparam logic [2:0] R_PR = 3'b100;

    localparam logic [5:0] U_MOV  = 6'b000001;
    localparam logic [5:0] U_SET0 = 6'b000010;
    localparam logic [5:0] U_AND  = 6'b001000;
    localparam logic [5:0] U_XNOR = 6'b010000;
    localparam logic [5:0] U_SEL  = 6'b100000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_BIT,
`ifdef BSLU_SEQ_CARRY_OUT_EN
        S_COUT,
`endif
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        op_q;
    logic [BC_W-1:0]   nbits_q, bit_q, bit_nx;
    logic [2:0]        step_q, step_nx, last_step;
    logic [ROW_AW-1:0] a_q, b_q, d_q;
    logic [ROW_AW-1:0] addr_a, addr_b, addr_d;
    logic              accept;

    assign accept    = cmd_valid && (state == S_IDLE);
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);

    // Row of bit i of each operand; wraps modulo 2^ROW_AW.
    assign addr_a = a_q + ROW_AW'(bit_q);
    assign addr_b = b_q + ROW_AW'(bit_q);
    assign addr_d = d_q + ROW_AW'(bit_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_q   <= '0;
            step_q  <= '0;
            op_q    <= '0;
            nbits_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
        end else begin
            state  <= state_nx;
            bit_q  <= bit_nx;
            step_q <= step_nx;
            if (accept) begin
                op_q    <= cmd_op;
                nbits_q <= BC_W'(cmd_nbits);
                a_q     <= cmd_a;
                b_q     <= cmd_b;
                d_q     <= cmd_d;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        bit_nx    = bit_q;
        step_nx   = step_q;
        uop_op    = '0;
        uop_rs1   = '0;
        uop_rs2   = '0;
        uop_rd    = '0;
        row_rd    = 1'b0;
        row_wr    = 1'b0;
        row_addr  = '0;
        last_step = 3'd7;

        case (op_q)
            OP_COPY: last_step = 3'd1;
            OP_AND:  last_step = 3'd4;
            OP_XOR:  last_step = 3'd6;
            default: last_step = 3'd7;
        endcase

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    bit_nx  = '0;
                    step_nx = '0;
                    if (cmd_nbits == '0)       state_nx = S_DONE;
                    else if (cmd_op == OP_ADD) state_nx = S_INIT;
                    else                       state_nx = S_BIT;
                end
            end
            S_INIT: begin
                if (!uop_stall) begin
                    uop_op   = U_SET0;
                    uop_rd   = R_CR;
                    state_nx = S_BIT;
                end
            end
            S_BIT: begin
                if (!uop_stall) begin
                    // Step tables: op in the upper bits, step index below.
                    case ({op_q, step_q})
                        {OP_COPY, 3'd0}, {OP_AND, 3'd0}, {OP_XOR, 3'd0}, {OP_ADD, 3'd0}: begin
                            row_rd = 1'b1; row_addr = addr_a;
                        end
                        {OP_AND, 3'd1}, {OP_XOR, 3'd1}, {OP_ADD, 3'd1}: begin
                            uop_op = U_MOV; uop_rs1 = R_SA; uop_rd = R_PR;
                        end
                        {OP_AND, 3'd2}, {OP_XOR, 3'd2}, {OP_ADD, 3'd2}, {OP_ADD, 3'd6}: begin
                            row_rd = 1'b1; row_addr = addr_b;
                        end
                        {OP_COPY, 3'd1}, {OP_AND, 3'd4}, {OP_XOR, 3'd6}, {OP_ADD, 3'd5}: begin
                            row_wr = 1'b1; row_addr = addr_d;
                        end
                        {OP_AND, 3'd3}: begin
                            uop_op = U_AND; uop_rs1 = R_SA; uop_rs2 = R_PR; uop_rd = R_SA;
                        end
                        {OP_XOR, 3'd3}: begin
                            uop_op = U_XNOR; uop_rs1 = R_SA; uop_rs2 = R_PR; uop_rd = R_PR;
                        end
                        {OP_XOR, 3'd4}: begin
                            uop_op = U_SET0; uop_rd = R_SA;
                        end
                        {OP_XOR, 3'd5}: begin
                            uop_op = U_XNOR; uop_rs1 = R_PR; uop_rs2 = R_SA; uop_rd = R_SA;
                        end
                        {OP_ADD, 3'd3}: begin
                            uop_op = U_XNOR; uop_rs1 = R_PR; uop_rs2 = R_SA; uop_rd = R_PR;
                        end
                        {OP_ADD, 3'd4}: begin
                            uop_op = U_XNOR; uop_rs1 = R_PR; uop_rs2 = R_CR; uop_rd = R_SA;
                        end
                        {OP_ADD, 3'd7}: begin
                            uop_op = U_SEL; uop_rs1 = R_SA; uop_rs2 = R_CR; uop_rd = R_CR;
                        end
                        default: ;
                    endcase

                    if (step_q == last_step) begin
                        step_nx = '0;
                        bit_nx  = bit_q + BC_W'(1);
                        if (bit_q == nbits_q - BC_W'(1)) begin
`ifdef BSLU_SEQ_CARRY_OUT_EN
                            state_nx = (op_q == OP_ADD) ? S_COUT : S_DONE;
`else
                            state_nx = S_DONE;
`endif
                        end
                    end else begin
                        step_nx = step_q + 3'd1;
                    end
                end
            end
`ifdef BSLU_SEQ_CARRY_OUT_EN
            S_COUT: begin
                if (!uop_stall) begin
                    if (step_q == 3'd0) begin
                        uop_op  = U_MOV; uop_rs1 = R_CR; uop_rd = R_SA;
                        step_nx = 3'd1;
                    end else begin
                        row_wr   = 1'b1;
                        row_addr = d_q + ROW_AW'(nbits_q);
                        step_nx  = '0;
                        state_nx = S_DONE;
                    end
                end
            end
`endif
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bslu_seq.sv
// tb_bslu_seq: runs bslu_seq's micro-op stream on a behavioural BSLU + row array and checks
// destination rows, cycle counts and strobe rules against plain arithmetic.
module tb_bslu_seq;
    localparam int unsigned ROW_AW = 10;
    localparam int unsigned NB_W   = 6;
    localparam int          NROWS  = 1 << ROW_AW;

    localparam logic [1:0] OP_COPY = 2'd0;
    localparam logic [1:0] OP_AND  = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_ADD  = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [NB_W-1:0]   cmd_nbits = '0;
    logic [ROW_AW-1:0] cmd_a = '0;
    logic [ROW_AW-1:0] cmd_b = '0;
    logic [ROW_AW-1:0] cmd_d = '0;
    logic              uop_stall = 1'b0;
    logic [5:0]        uop_op;
    logic [2:0]        uop_rs1, uop_rs2, uop_rd;
    logic              row_rd, row_wr;
    logic [ROW_AW-1:0] row_addr;
    logic              busy, done;

    bslu_seq #(.ROW_AW(ROW_AW), .NB_W(NB_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_nbits(cmd_nbits), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d),
        .uop_stall(uop_stall), .uop_op(uop_op), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2),
        .uop_rd(uop_rd), .row_rd(row_rd), .row_wr(row_wr), .row_addr(row_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic mem [NROWS];
    logic m_sa, m_cr, m_pr;
    int   trace[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic src(input logic [2:0] sel);
        case (sel)
            3'b001:  return m_sa;
            3'b010:  return m_cr;
            3'b100:  return m_pr;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural BSLU: all sources read before the destination is written.
    task automatic apply_uop();
        logic s1, s2, v;
        s1 = src(uop_rs1);
        s2 = src(uop_rs2);
        v  = 1'b0;
        if (uop_op[0]) v = s1;
        if (uop_op[1]) v = uop_op[2];
        if (uop_op[3]) v = s1 & s2;
        if (uop_op[4]) v = ~(s1 ^ s2);
        if (uop_op[5]) v = m_pr ? s1 : s2;
        case (uop_rd)
            3'b001:  m_sa = v;
            3'b010:  m_cr = v;
            3'b100:  m_pr = v;
            default: ;
        endcase
    endtask

    function automatic int exp_cycles(input logic [1:0] op, input int n);
        if (n == 0) return 0;
        case (op)
            OP_COPY: return 2 * n;
            OP_AND:  return 5 * n;
            OP_XOR:  return 7 * n;
`ifdef BSLU_SEQ_CARRY_OUT_EN
            default: return 3 + 8 * n;
`else
            default: return 1 + 8 * n;
`endif
        endcase
    endfunction

    function automatic logic [63:0] exp_result(input logic [1:0] op, input logic [63:0] av,
                                               input logic [63:0] bv, input int n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        case (op)
            OP_COPY: return av & mask;
            OP_AND:  return av & bv & mask;
            OP_XOR:  return (av ^ bv) & mask;
            default: return (av + bv) & mask;
        endcase
    endfunction

    // Issues one command and plays the resulting stream into the model.
    // done_cyc = cycles from accept to done, or -2 when aborted by reset at abort_at.
    task automatic run_cmd(input logic [1:0] op, input int n, input int a, input int b, input int d,
                           input int stall_at, input int stall_len, input int abort_at,
                           output int active, output int done_cyc, output int stalled);
        int left;
        int acts;
        trace.delete();
        active = 0; done_cyc = -1; stalled = 0; left = stall_len;
        m_sa = 1'($urandom); m_cr = 1'($urandom); m_pr = 1'($urandom);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_nbits = NB_W'(n);
        cmd_a = ROW_AW'(a); cmd_b = ROW_AW'(b); cmd_d = ROW_AW'(d);
        @(negedge clk);
        check("ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_nbits = NB_W'($urandom);
        cmd_a = ROW_AW'($urandom); cmd_b = ROW_AW'($urandom); cmd_d = ROW_AW'($urandom);
        for (int k = 1; k <= 2000; k++) begin
            uop_stall = (stall_at >= 0) && (left > 0) && (active == stall_at);
            if (uop_stall) left--;
            if (abort_at >= 0 && active == abort_at) rst = 1'b1;
            @(negedge clk);
            if (done) begin
                done_cyc = k;
                break;
            end
            if (rst) begin
                @(posedge clk); #1;
                rst = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    check("abort_quiet", {uop_op, uop_rs1, uop_rs2, uop_rd, row_rd, row_wr,
                                          row_addr, busy, done}, 0);
                    check("abort_ready", cmd_ready, 1);
                    @(posedge clk); #1;
                end
                done_cyc = -2;
                return;
            end
            check("busy_flags", {busy, done, cmd_ready}, 3'b100);
            if (uop_stall) begin
                stalled++;
                check("stall_quiet", {uop_op, uop_rs1, uop_rs2, uop_rd, row_rd, row_wr, row_addr}, 0);
            end else begin
                acts = int'(uop_op != '0) + int'(row_rd) + int'(row_wr);
                check("one_action", acts, 1);
                if (!row_rd && !row_wr) check("addr_zero", row_addr, 0);
                if (row_rd) begin
                    m_sa = mem[int'(row_addr)];
                    trace.push_back(int'(row_addr));
                end
                if (row_wr) begin
                    mem[int'(row_addr)] = m_sa;
                    trace.push_back(4096 + int'(row_addr));
                end
                if (uop_op != '0) apply_uop();
                active++;
            end
            @(posedge clk); #1;
        end
        uop_stall = 1'b0;
        if (done_cyc == -1) check("done_timeout", 0, 1);
    endtask

    task automatic exec_cmd(input string name, input logic [1:0] op, input int n, input int a,
                            input int b, input int d, input logic [63:0] av, input logic [63:0] bv,
                            input int stall_at, input int stall_len);
        logic [63:0] got;
        logic        row_prev, row_exp;
        int          active, done_cyc, stalled;
        for (int i = 0; i < NROWS; i++) mem[i] = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            mem[(a + i) % NROWS] = av[i];
            if (op != OP_COPY) mem[(b + i) % NROWS] = bv[i];
        end
        row_prev = mem[(d + n) % NROWS];
        run_cmd(op, n, a, b, d, stall_at, stall_len, -1, active, done_cyc, stalled);
        got = '0;
        for (int i = 0; i < n; i++) got[i] = mem[(d + i) % NROWS];
        check({name, "_result"}, got, exp_result(op, av, bv, n));
        row_exp = row_prev;
`ifdef BSLU_SEQ_CARRY_OUT_EN
        if (op == OP_ADD && n > 0)
            row_exp = 1'((((av & ((64'd1 << n) - 64'd1)) + (bv & ((64'd1 << n) - 64'd1))) >> n));
`endif
        check({name, "_row_dn"}, mem[(d + n) % NROWS], row_exp);
        check({name, "_active"}, active, exp_cycles(op, n));
        check({name, "_done_lat"}, done_cyc, exp_cycles(op, n) + stalled + 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int active, done_cyc, stalled, n, a, sa, sl;
        logic [1:0]  op;
        logic [63:0] av, bv;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_flags", {cmd_ready, busy, done}, 3'b100);
        check("reset_uop", {uop_op, uop_rs1, uop_rs2, uop_rd, row_rd, row_wr, row_addr}, 0);

        exec_cmd("copy3", OP_COPY, 3, 5, 500, 40, 64'h5, 64'h0, -1, 0);
        check("copy3_len", trace.size(), 6);
        for (int i = 0; i < 3 && trace.size() == 6; i++) begin
            check("copy3_rd", trace[2 * i], 5 + i);
            check("copy3_wr", trace[2 * i + 1], 4096 + 40 + i);
        end

        exec_cmd("add_7_3", OP_ADD, 4, 100, 200, 300, 64'h7, 64'h3, -1, 0);
        exec_cmd("add_f_1", OP_ADD, 4, 100, 200, 300, 64'hF, 64'h1, -1, 0);
        exec_cmd("and_8", OP_AND, 8, 10, 80, 150, 64'hA5, 64'h3C, -1, 0);
        exec_cmd("xor_8", OP_XOR, 8, 10, 80, 150, 64'hA5, 64'h3C, -1, 0);
        exec_cmd("add_stall", OP_ADD, 4, 100, 200, 300, 64'h7, 64'h3, 19, 3);
        exec_cmd("add_wrap", OP_ADD, 63, 1000, 40, 104, {$urandom, $urandom}, {$urandom, $urandom}, -1, 0);

        run_cmd(OP_XOR, 8, 10, 80, 150, -1, 0, 11, active, done_cyc, stalled);
        check("abort_marker", done_cyc, -2);
        check("abort_point", active, 11);
        exec_cmd("zero_len", OP_ADD, 0, 10, 80, 150, 64'h0, 64'h0, -1, 0);

        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom);
            n  = (t % 10 == 9) ? 63 : int'($urandom_range(0, 63));
            a  = int'($urandom_range(0, NROWS - 1));
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            sa = -1; sl = 0;
            if (exp_cycles(op, n) > 0 && $urandom_range(0, 2) == 0) begin
                sa = int'($urandom_range(0, exp_cycles(op, n) - 1));
                sl = int'($urandom_range(1, 4));
            end
            exec_cmd("rand", op, n, a, (a + 64) % NROWS, (a + 128) % NROWS, av, bv, sa, sl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
